// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand select encoding and the divider FSM state encoding.
package alu_pkg;

  localparam int DIV_WIDTH = 8;

  // Signed/unsigned select, common to the multipliers and the divider.
  localparam logic SEL_UNSIGNED = 1'b0;
  localparam logic SEL_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    DIV_ST_IDLE = 2'd0,
    DIV_ST_CALC = 2'd1,
    DIV_ST_FIX  = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, keep or restore.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {2'b00, divisor_mag};
    // A clear borrow bit means the trial subtraction did not go negative.
    q_bit   = ~diff[WIDTH+1];
    rem_out = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/seq_divider_8.sv
// Multi-cycle restoring divider with start/busy/done handshake, unsigned or signed operands.
// Optional `DIV_ZERO_FAST_EN: a zero divisor skips the iteration phase and completes in one cycle.
module seq_divider_8
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             div_sel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem, rem_step;
  logic [WIDTH-1:0] quot, div_mag, dividend_raw;
  logic             sign_a, sign_b, div_zero, q_bit;

  logic             accept, in_signed, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;

  always_comb begin
    accept    = start && (state == DIV_ST_IDLE);
    in_signed = (div_sel == SEL_SIGNED);
    a_neg     = in_signed && dividend[WIDTH-1];
    b_neg     = in_signed && divisor[WIDTH-1];
    // The most negative value negates to itself, which read unsigned is its true magnitude.
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in       (rem),
    .dividend_bit (quot[WIDTH-1]),
    .divisor_mag  (div_mag),
    .rem_out      (rem_step),
    .q_bit        (q_bit)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= DIV_ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      DIV_ST_IDLE: if (start) begin
`ifdef DIV_ZERO_FAST_EN
        state_next = (divisor == '0) ? DIV_ST_FIX : DIV_ST_CALC;
`else
        state_next = DIV_ST_CALC;
`endif
      end
      DIV_ST_CALC: if (cnt == CNT_LAST) state_next = DIV_ST_FIX;
      DIV_ST_FIX:  state_next = DIV_ST_IDLE;
      default:     state_next = DIV_ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != DIV_ST_IDLE);
  end

  // NOTE: working registers are always loaded on accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem          <= '0;
      quot         <= a_mag;
      div_mag      <= b_mag;
      dividend_raw <= dividend;
      sign_a       <= a_neg;
      sign_b       <= b_neg;
      div_zero     <= (divisor == '0);
      cnt          <= '0;
    end else if (state == DIV_ST_CALC) begin
      // Dividend bits leave the top of quot while quotient bits enter at the bottom.
      rem  <= rem_step;
      quot <= {quot[WIDTH-2:0], q_bit};
      cnt  <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == DIV_ST_FIX) begin
        done <= 1'b1;
        if (div_zero) begin
          quotient    <= '1;
          remainder   <= dividend_raw;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= (sign_a ^ sign_b) ? -quot : quot;
          remainder   <= sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_divider_8.sv
// Scoreboard bench for seq_divider_8: directed vectors, mid-operation reset, random ops in both modes.
module tb_seq_divider_8;

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif
  localparam int FULL_LAT = 9;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         accept;
    int         lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       div_sel = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;
  exp_t sb[$];

  seq_divider_8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .div_sel     (div_sel),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  function automatic exp_t model(input bit sel, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   sa, sb_i, qi, ri;
    e.accept = 0;
    e.lat    = (b == 8'h00 && FAST_DZ) ? 1 : FULL_LAT;
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.dz = 1'b1;
    end else if (!sel) begin
      e.q = a / b; e.r = a % b; e.dz = 1'b0;
    end else begin
      sa   = $signed(a);
      sb_i = $signed(b);
      qi   = sa / sb_i;
      ri   = sa % sb_i;
      e.q = qi[7:0]; e.r = ri[7:0]; e.dz = 1'b0;
    end
    return e;
  endfunction

  // Waits for an idle cycle, drives one request, and optionally registers its expected result.
  task automatic issue(input bit sel, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] q, input logic [7:0] r, input bit dz, input bit push);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("issue_wait_busy", {31'd0, busy}, 32'd0);
    div_sel  = sel;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.q = q; e.r = r; e.dz = dz;
      e.accept = cycle + 1;
      e.lat    = (b == 8'h00 && FAST_DZ) ? 1 : FULL_LAT;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    @(negedge clk);
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic issue_model(input bit sel, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e = model(sel, a, b);
    issue(sel, a, b, e.q, e.r, e.dz, 1'b1);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 q=%0h r=%0h, required no done", quotient, remainder);
      end else begin
        e = sb.pop_front();
        check("quotient", {24'd0, quotient}, {24'd0, e.q});
        check("remainder", {24'd0, remainder}, {24'd0, e.r});
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        check("latency", cycle - e.accept, e.lat);
        check("busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   n;
    logic [7:0] a, b;

    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_quotient", {24'd0, quotient}, 32'd0);
    check("rst_remainder", {24'd0, remainder}, 32'd0);
    check("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    issue(1'b0, 8'd100, 8'd7, 8'h0E, 8'h02, 1'b0, 1'b1);
    issue(1'b1, 8'h9C,  8'h07, 8'hF2, 8'hFE, 1'b0, 1'b1);
    issue(1'b1, 8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b1);
    issue(1'b1, 8'h80,  8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);
    issue(1'b0, 8'h5A,  8'h00, 8'hFF, 8'h5A, 1'b1, 1'b1);
    issue(1'b1, 8'hA6,  8'h00, 8'hFF, 8'hA6, 1'b1, 1'b1);
    issue(1'b1, 8'h80,  8'h03, 8'hD6, 8'hFE, 1'b0, 1'b1);

    // Requests raised while busy must be dropped.
    issue(1'b0, 8'd200, 8'd3, 8'h42, 8'h02, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("busy_during_repulse", {31'd0, busy}, 32'd1);
      start    = 1'b1;
      div_sel  = 1'b0;
      dividend = 8'h11;
      divisor  = 8'h02;
    end
    @(negedge clk);
    start = 1'b0;

    // Reset in the middle of an operation: no done, outputs cleared.
    issue(1'b0, 8'd77, 8'd5, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_quotient", {24'd0, quotient}, 32'd0);
    check("midrst_remainder", {24'd0, remainder}, 32'd0);
    check("midrst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    issue(1'b0, 8'd255, 8'd1, 8'hFF, 8'h00, 1'b0, 1'b1);

    for (int mode = 0; mode < 2; mode++) begin
      for (int i = 0; i < 2000; i++) begin
        a = 8'($urandom);
        b = 8'($urandom);
        n = $urandom_range(0, 19);
        if (n == 0) b = 8'h00;
        else if (n == 1) begin a = 8'h80; b = 8'hFF; end
        issue_model(mode[0], a, b);
      end
    end

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", sb.size(), 32'd0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
